// File: rtl/radix4_multiplier.sv
// radix4_multiplier
//   Sequential radix-4 Booth multiplier. One Booth digit is retired per clock.
//   A product of two WIDTH-bit operands takes WIDTH/2+1 cycles.
//
// Configuration macro:
//   MUL_SIGNED_EN  when defined, adds the op_signed port so that each operation
//                  can select two's-complement or unsigned operands. When it is
//                  not defined, all operands are unsigned.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   multiplier    operand A (WIDTH bits)
//   multiplicand  operand B (WIDTH bits)
//   op_start      start request; accepted in IDLE/DONE
//   op_clear      synchronous abort/clear; has priority over op_start
//   op_signed     1 = signed operands, 0 = unsigned (MUL_SIGNED_EN only)
//   op_done       result valid; held in DONE
//   result        low 2*WIDTH bits of the product; zero outside DONE
module radix4_multiplier #(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic                 op_start,
  input  logic                 op_clear,
`ifdef MUL_SIGNED_EN
  input  logic                 op_signed,
`endif
  output logic                 op_done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int EW = WIDTH + 2;        // extended operand width
  localparam int HW = WIDTH + 4;        // upper accumulator half, headroom for +-2M
  localparam int L  = WIDTH / 2 + 1;    // Booth digits per operation
  localparam int CW = $clog2(L + 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                 state, state_nxt;
  logic [HW-1:0]          hi;       // upper partial product
  logic [EW-1:0]          q;        // multiplier bits not yet consumed / low product bits
  logic                   q_prev;   // bit to the right of the current digit
  logic [EW-1:0]          mcand;
  logic [CW-1:0]          cnt;

  logic                   is_signed;
  logic [EW-1:0]          a_ext, b_ext;
  logic [HW-1:0]          m_w, addend, hi_sum;
  logic signed [HW+EW-1:0] shifted;
  logic                   last;

`ifdef MUL_SIGNED_EN
  assign is_signed = op_signed;
`else
  assign is_signed = 1'b0;
`endif

  always_comb begin
    a_ext = {{2{is_signed & multiplier[WIDTH-1]}}, multiplier};
    b_ext = {{2{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
    m_w   = {{2{mcand[EW-1]}}, mcand};
    case ({q[1:0], q_prev})
      3'b001, 3'b010: addend = m_w;
      3'b011:         addend = m_w << 1;
      3'b100:         addend = '0 - (m_w << 1);
      3'b101, 3'b110: addend = '0 - m_w;
      default:        addend = '0;
    endcase
    hi_sum = hi + addend;
    // {hi,q} is one arithmetic register: after L shifts the consumed multiplier
    // bits in q have been replaced by the low product bits.
    shifted = $signed({hi_sum, q}) >>> 2;
    last    = (cnt == CW'(L - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (op_clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (op_start) state_nxt = EXEC;
        EXEC:    if (last)     state_nxt = DONE;
        DONE:    if (op_start) state_nxt = EXEC;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi      <= '0;
      q       <= '0;
      q_prev  <= 1'b0;
      mcand   <= '0;
      cnt     <= '0;
      op_done <= 1'b0;
      result  <= '0;
    end else if (op_clear) begin
      hi      <= '0;
      q       <= '0;
      q_prev  <= 1'b0;
      cnt     <= '0;
      op_done <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (op_start) begin
            q       <= a_ext;
            mcand   <= b_ext;
            hi      <= '0;
            q_prev  <= 1'b0;
            cnt     <= '0;
            op_done <= 1'b0;
            result  <= '0;
          end
        end
        EXEC: begin
          hi     <= shifted[HW+EW-1:EW];
          q      <= shifted[EW-1:0];
          q_prev <= q[1];
          if (last) begin
            cnt     <= '0;
            op_done <= 1'b1;
            result  <= shifted[2*WIDTH-1:0];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/radix4_multiplier.md
RADIX4_MULTIPLIER -- requirements
Module: radix4_multiplier

Interface
REQ-001 SHALL have parameter: WIDTH, default 64, operand width in bits (even, >= 4).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: multiplier  input  WIDTH  operand A.
REQ-005 SHALL have port: multiplicand  input  WIDTH  operand B.
REQ-006 SHALL have port: op_start  input  1  start request, sampled on clk.
REQ-007 SHALL have port: op_clear  input  1  synchronous abort/clear.
REQ-008 SHALL have port: op_signed  input  1  1 = two's-complement operands, 0 = unsigned (present only with MUL_SIGNED_EN).
REQ-009 SHALL have port: op_done  output  1  result valid.
REQ-010 SHALL have port: result  output  2*WIDTH  product.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-012 SHALL, in IDLE or DONE with op_start=1 and op_clear=0, latch both operands (and op_signed), clear accumulator, clear op_done, set digit counter to 0, and enter EXEC.
REQ-013 SHALL sign-/zero-extend operands to WIDTH+2 bits per mode and process exactly L = WIDTH/2+1 radix-4 Booth digits, one digit per EXEC cycle.
REQ-014 SHALL recode each digit from 3 multiplier bits to {-2,-1,0,+1,+2} x multiplicand, add to the 2*WIDTH+2-bit accumulator, then arithmetic-shift the partial product by 2.
REQ-015 SHALL, on the edge completing digit L-1, enter DONE, drive result = low 2*WIDTH bits of exact product, and assert op_done; op_done rises exactly L cycles after the edge that sampled op_start.
REQ-016 SHALL hold result and op_done stable in DONE until op_clear or a new op_start.
REQ-017 SHALL ignore op_start while in EXEC; operand changes after the sampling edge SHALL NOT affect the result.
REQ-018 SHALL give op_clear priority over op_start in every state: next state IDLE, result = 0, op_done = 0, counter = 0.
REQ-019 SHALL keep result = 0 and op_done = 0 during IDLE and EXEC (intermediate accumulator not visible).
REQ-020 SHALL produce correct results for the boundary operands 0, all-ones, and most-negative (signed), with no overflow indication required.

Reset
REQ-021 SHALL, on reset=1 asynchronously and in any state including mid-EXEC, force state IDLE, op_done = 0, result = 0, counter = 0, and accumulator = 0.
REQ-022 SHALL accept op_start on the first rising edge after reset deasserts.

Configuration
REQ-023 SHALL, with macro MUL_SIGNED_EN defined, provide the op_signed port and select signed or unsigned operation per operation.
REQ-024 SHALL, without MUL_SIGNED_EN, omit op_signed and treat all operands as unsigned (zero extension); latency L SHALL be unchanged.

Verification (WIDTH=64, MUL_SIGNED_EN defined)
REQ-025 SHALL verify signed operation: multiplier=64'h11, multiplicand=-3, op_signed=1, op_start pulse -> op_done rises 33 cycles later with result=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFCD.
REQ-026 SHALL verify unsigned operation: same operands with op_signed=0 -> result=128'h0000_0000_0000_0010_FFFF_FFFF_FFFF_FFCD.
REQ-027 SHALL verify abort: start 0x11 x 0x43, assert op_clear 10 cycles in -> op_done never rises and result=0; a restart then yields result=128'h473 after 33 cycles.
REQ-028 SHALL verify start and clear interactions: op_start and op_clear high on the same edge -> stays IDLE; op_start mid-EXEC -> ignored, original result delivered on schedule.
REQ-029 SHALL verify async reset: assert reset mid-EXEC, between clock edges -> op_done=0 and result=0 immediately; a following start completes normally.
REQ-030 SHALL verify the most-negative case: multiplier=multiplicand=64'h8000_0000_0000_0000 signed -> result=128'h4000_0000_0000_0000_0000_0000_0000_0000.
